// File: rtl/megaram_mem_bridge.sv
// Bridges MegaRAM cartridge bus cycles onto a req/ack memory port.
// A single-entry read cache lets repeated reads of one address complete without stalling the Z80.
module megaram_mem_bridge #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter bit CACHE_EN       = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cart_ena,
    input  logic        ram_ena,
    input  logic [22:0] mem_addr,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic [7:0]  cdin,
    input  logic        cache_flush,
    output logic        mem_req,
    output logic        mem_we,
    output logic [22:0] mem_a,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  cdout,
    output logic        data_oe,
    output logic        wait_n,
    output logic        timeout_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t        state;
    logic [CW-1:0] tmo_cnt;
    logic          cache_valid;
    logic [22:0]   cache_tag;
    logic [7:0]    cache_data;
    logic          rd_trig;
    logic          wr_trig;
    logic          hit;

    // Simultaneous rd_n/wr_n is treated as a glitch and starts nothing.
    always_comb begin
        rd_trig = cart_ena && !rd_n && wr_n;
        wr_trig = cart_ena && !wr_n && rd_n && ram_ena;
        hit     = CACHE_EN && cache_valid && (cache_tag == mem_addr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_a       <= '0;
            mem_wdata   <= '0;
            cdout       <= 8'hFF;
            data_oe     <= 1'b0;
            wait_n      <= 1'b1;
            timeout_err <= 1'b0;
            tmo_cnt     <= '0;
            cache_valid <= 1'b0;
            cache_tag   <= '0;
            cache_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_trig && hit) begin
                        state   <= HOLD;
                        cdout   <= cache_data;
                        data_oe <= 1'b1;
                    end else if (rd_trig || wr_trig) begin
                        state     <= REQ;
                        mem_req   <= 1'b1;
                        wait_n    <= 1'b0;
                        mem_a     <= mem_addr;
                        mem_we    <= wr_trig;
                        mem_wdata <= cdin;
                        tmo_cnt   <= '0;
                    end
                end
                REQ: begin
                    // An ack in the final counted cycle still wins over the abort.
                    if (mem_ack) begin
                        state   <= HOLD;
                        mem_req <= 1'b0;
                        wait_n  <= 1'b1;
                        data_oe <= !mem_we;
                        if (!mem_we) begin
                            cdout       <= mem_rdata;
                            cache_valid <= 1'b1;
                            cache_tag   <= mem_a;
                            cache_data  <= mem_rdata;
                        end else if (cache_tag == mem_a) begin
                            cache_data <= mem_wdata;
                        end
                    end else if (tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        state       <= HOLD;
                        mem_req     <= 1'b0;
                        wait_n      <= 1'b1;
                        cdout       <= 8'hFF;
                        data_oe     <= !mem_we;
                        timeout_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if ((rd_n && wr_n) || !cart_ena) begin
                        state   <= IDLE;
                        data_oe <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            if (cache_flush)
                cache_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_megaram_mem_bridge.sv
// Self-checking bench for megaram_mem_bridge: the bench plays the memory and predicts
// bus results from a byte-addressed memory model plus an abstract view of the cache.
module tb_megaram_mem_bridge;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cart_ena = 1'b0;
    logic        ram_ena = 1'b1;
    logic [22:0] mem_addr = '0;
    logic        rd_n = 1'b1;
    logic        wr_n = 1'b1;
    logic [7:0]  cdin = '0;
    logic        cache_flush = 1'b0;
    logic        mem_req;
    logic        mem_we;
    logic [22:0] mem_a;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = '0;
    logic [7:0]  cdout;
    logic        data_oe;
    logic        wait_n;
    logic        timeout_err;

    int errors = 0;
    int checks = 0;

    // Reference state: memory contents, which address the cache holds, sticky error, bus data
    logic [7:0]  memArr [logic [22:0]];
    bit          cValid = 1'b0;
    logic [22:0] cTag = '0;
    bit          errFlag = 1'b0;
    logic [7:0]  expCd = 8'hFF;

    megaram_mem_bridge #(.TIMEOUT_CYCLES(TMO), .CACHE_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .cart_ena(cart_ena), .ram_ena(ram_ena),
        .mem_addr(mem_addr), .rd_n(rd_n), .wr_n(wr_n), .cdin(cdin),
        .cache_flush(cache_flush), .mem_req(mem_req), .mem_we(mem_we),
        .mem_a(mem_a), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .cdout(cdout), .data_oe(data_oe),
        .wait_n(wait_n), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] memVal(input logic [22:0] a);
        if (memArr.exists(a))
            return memArr[a];
        return a[7:0] ^ 8'h5A;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1; rd_n = 1'b1; wr_n = 1'b1; mem_ack = 1'b0;
        @(negedge clk);
        checkOutput("rst_req", mem_req, 0);
        checkOutput("rst_we", mem_we, 0);
        checkOutput("rst_a", mem_a, 0);
        checkOutput("rst_wdata", mem_wdata, 0);
        checkOutput("rst_cdout", cdout, 8'hFF);
        checkOutput("rst_oe", data_oe, 0);
        checkOutput("rst_wait", wait_n, 1);
        checkOutput("rst_terr", timeout_err, 0);
        reset = 1'b0;
        cValid = 1'b0; errFlag = 1'b0; expCd = 8'hFF;
    endtask

    // ackDelay < 0 means the memory never answers
    task automatic applyStimulus(input bit isRead, input logic [22:0] addr, input logic [7:0] wdat,
                                 input int ackDelay, input bit flushAtAck);
        bit hit;
        int reqCycles;
        int waitLow;
        int guard;
        hit = isRead && cValid && (cTag == addr);
        @(negedge clk);
        cart_ena = 1'b1; ram_ena = 1'b1; mem_addr = addr; cdin = wdat;
        rd_n = !isRead; wr_n = isRead;
        @(negedge clk);
        if (hit) begin
            checkOutput("hit_req", mem_req, 0);
            checkOutput("hit_wait", wait_n, 1);
            checkOutput("hit_oe", data_oe, 1);
            checkOutput("hit_data", cdout, memVal(addr));
            expCd = memVal(addr);
        end else begin
            checkOutput("req_start", mem_req, 1);
            checkOutput("req_addr", mem_a, addr);
            checkOutput("req_we", mem_we, !isRead);
            if (!isRead)
                checkOutput("req_wdata", mem_wdata, wdat);
            checkOutput("req_wait", wait_n, 0);
            if (ackDelay >= 0) begin
                reqCycles = 1; waitLow = 1;
                repeat (ackDelay) begin
                    @(negedge clk);
                    reqCycles += int'(mem_req);
                    waitLow += int'(!wait_n);
                end
                mem_ack = 1'b1;
                mem_rdata = isRead ? memVal(addr) : 8'h00;
                cache_flush = flushAtAck;
                @(negedge clk);
                mem_ack = 1'b0; cache_flush = 1'b0; mem_rdata = 8'($urandom);
                checkOutput("req_cycles", reqCycles, ackDelay + 1);
                checkOutput("wait_cycles", waitLow, ackDelay + 1);
                checkOutput("done_req", mem_req, 0);
                checkOutput("done_wait", wait_n, 1);
                if (isRead) begin
                    checkOutput("rd_oe", data_oe, 1);
                    checkOutput("rd_data", cdout, memVal(addr));
                    expCd = memVal(addr);
                    cValid = !flushAtAck;
                    cTag = addr;
                end else begin
                    checkOutput("wr_oe", data_oe, 0);
                    memArr[addr] = wdat;
                    if (flushAtAck)
                        cValid = 1'b0;
                end
            end else begin
                reqCycles = 1; guard = 0;
                while (mem_req === 1'b1 && guard < 20) begin
                    @(negedge clk);
                    if (mem_req === 1'b1)
                        reqCycles++;
                    guard++;
                end
                checkOutput("tmo_cycles", reqCycles, TMO);
                checkOutput("tmo_wait", wait_n, 1);
                checkOutput("tmo_cdout", cdout, 8'hFF);
                checkOutput("tmo_oe", data_oe, isRead);
                expCd = 8'hFF;
                errFlag = 1'b1;
            end
        end
        checkOutput("terr", timeout_err, errFlag);
        rd_n = 1'b1; wr_n = 1'b1;
        @(negedge clk);
        checkOutput("rel_oe", data_oe, 0);
        checkOutput("rel_wait", wait_n, 1);
        checkOutput("rel_cdout", cdout, expCd);
    endtask

    task automatic noTrigger(input bit rdn, input bit wrn, input bit ramEna, input logic [7:0] wdat);
        @(negedge clk);
        cart_ena = 1'b1; ram_ena = ramEna; mem_addr = 23'h420005; cdin = wdat;
        rd_n = rdn; wr_n = wrn;
        repeat (2) begin
            @(negedge clk);
            checkOutput("notrig_req", mem_req, 0);
            checkOutput("notrig_wait", wait_n, 1);
            checkOutput("notrig_oe", data_oe, 0);
        end
        rd_n = 1'b1; wr_n = 1'b1; ram_ena = 1'b1;
        @(negedge clk);
    endtask

    task automatic flushCache();
        @(negedge clk);
        cache_flush = 1'b1;
        @(negedge clk);
        cache_flush = 1'b0;
        cValid = 1'b0;
    endtask

    logic [22:0] addrs [4];
    int op;

    initial begin
        addrs[0] = 23'h420005; addrs[1] = 23'h420006;
        addrs[2] = 23'h000000; addrs[3] = 23'h7FFFFF;
        memArr[23'h420005] = 8'hA5;

        doReset();

        applyStimulus(1'b1, 23'h420005, 8'h00, 2, 1'b0);
        applyStimulus(1'b1, 23'h420005, 8'h00, 0, 1'b0);
        noTrigger(1'b1, 1'b0, 1'b0, 8'h07);
        applyStimulus(1'b0, 23'h420005, 8'h3C, 1, 1'b0);
        applyStimulus(1'b1, 23'h420005, 8'h00, 0, 1'b0);
        noTrigger(1'b0, 1'b0, 1'b1, 8'h55);
        applyStimulus(1'b1, 23'h000123, 8'h00, 3, 1'b0);
        applyStimulus(1'b1, 23'h000200, 8'h00, 1, 1'b1);
        applyStimulus(1'b1, 23'h000200, 8'h00, 0, 1'b0);
        applyStimulus(1'b1, 23'h7FFFFF, 8'h00, -1, 1'b0);
        applyStimulus(1'b1, 23'h7FFFFF, 8'h00, 0, 1'b0);

        // Reset lands in the second REQ cycle, then a stale ack arrives
        applyStimulus(1'b1, 23'h420005, 8'h00, 0, 1'b0);
        @(negedge clk);
        cart_ena = 1'b1; mem_addr = 23'h420006; rd_n = 1'b0; wr_n = 1'b1;
        @(negedge clk);
        checkOutput("rstreq_req", mem_req, 1);
        @(negedge clk);
        reset = 1'b1; rd_n = 1'b1;
        @(negedge clk);
        checkOutput("rstreq_req0", mem_req, 0);
        checkOutput("rstreq_cdout", cdout, 8'hFF);
        checkOutput("rstreq_oe", data_oe, 0);
        reset = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h11;
        @(negedge clk);
        mem_ack = 1'b0;
        checkOutput("late_ack_req", mem_req, 0);
        checkOutput("late_ack_cdout", cdout, 8'hFF);
        checkOutput("late_ack_wait", wait_n, 1);
        cValid = 1'b0; errFlag = 1'b0; expCd = 8'hFF;
        applyStimulus(1'b1, 23'h420005, 8'h00, 1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 99));
            if (op < 55)
                applyStimulus(1'b1, addrs[$urandom_range(0, 3)], 8'h00,
                              int'($urandom_range(0, 2)), ($urandom_range(0, 9) == 0));
            else if (op < 80)
                applyStimulus(1'b0, addrs[$urandom_range(0, 3)], 8'($urandom),
                              int'($urandom_range(0, 2)), 1'b0);
            else if (op < 88)
                noTrigger(1'b1, 1'b0, 1'b0, 8'($urandom));
            else if (op < 95)
                flushCache();
            else
                applyStimulus(1'b1, addrs[$urandom_range(0, 3)], 8'h00, -1, 1'b0);
        end

        doReset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
